// File: rtl/guess_entry.sv
// Player digit-entry block for the number-guessing game: synchronised, debounced
// enter button, one-hot switch decoding, backspace/clear editing, packed guess output.
module guess_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DIGIT_W         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int SW_W = 2**DIGIT_W,
  localparam int CW   = $clog2(NUM_DIGITS + 1),
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SW_W-1:0]               switches,
  input  logic                          en,
  input  logic                          button,
  input  logic                          del,
  input  logic                          clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0] player_input,
  output logic [CW-1:0]                 digit_count,
  output logic                          finished,
  output logic                          accepted,
  output logic                          invalid
);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_DONE    = 1'b1
  } state_e;

  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(NUM_DIGITS);

  function automatic logic is_one_hot(input logic [SW_W-1:0] v);
    logic [DIGIT_W:0] n;
    n = '0;
    for (int i = 0; i < SW_W; i++) begin
      n = n + {{DIGIT_W{1'b0}}, v[i]};
    end
    return (n == {{DIGIT_W{1'b0}}, 1'b1});
  endfunction

  function automatic logic [DIGIT_W-1:0] one_hot_index(input logic [SW_W-1:0] v);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (v[i]) begin
        idx = DIGIT_W'(i);
      end
    end
    return idx;
  endfunction

  logic [1:0]         sync_q;
  logic               stb_q, stb_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               press_s;
  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DIGIT_W-1:0] digits_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] digits_d [NUM_DIGITS];
  logic               finished_q, finished_d;
  logic               accepted_q, accepted_d;
  logic               invalid_q, invalid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b00;
      stb_q      <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= S_COLLECT;
      count_q    <= '0;
      finished_q <= 1'b0;
      accepted_q <= 1'b0;
      invalid_q  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digits_q[k] <= '0;
      end
    end else begin
      sync_q     <= {sync_q[0], button};
      stb_q      <= stb_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      count_q    <= count_d;
      finished_q <= finished_d;
      accepted_q <= accepted_d;
      invalid_q  <= invalid_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digits_q[k] <= digits_d[k];
      end
    end
  end

  // Press fires on the same edge the debounced level rises, keeping latency at D+2.
  always_comb begin
    stb_d    = stb_q;
    db_cnt_d = db_cnt_q;
    press_s  = 1'b0;
    if (sync_q[1] != stb_q) begin
      if (db_cnt_q == DB_MAX) begin
        stb_d    = sync_q[1];
        db_cnt_d = '0;
        press_s  = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    digits_d   = digits_q;
    finished_d = finished_q;
    accepted_d = 1'b0;
    invalid_d  = 1'b0;
    if (clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digits_d[k] = '0;
      end
      count_d    = '0;
      finished_d = 1'b0;
      state_d    = S_COLLECT;
    end else if (en && del) begin
      case (state_q)
        S_COLLECT: begin
          if (count_q != '0) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
              if (CW'(k + 1) == count_q) begin
                digits_d[k] = '0;
              end else begin
                digits_d[k] = digits_q[k];
              end
            end
            count_d = count_q - CW'(1);
          end else begin
            count_d = count_q;
          end
        end
        S_DONE: begin
          digits_d[NUM_DIGITS-1] = '0;
          count_d    = CW'(NUM_DIGITS - 1);
          finished_d = 1'b0;
          state_d    = S_COLLECT;
        end
        default: begin
          state_d = S_COLLECT;
        end
      endcase
    end else if (en && press_s && (state_q == S_COLLECT)) begin
      if (is_one_hot(switches)) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (CW'(k) == count_q) begin
            digits_d[k] = one_hot_index(switches);
          end else begin
            digits_d[k] = digits_q[k];
          end
        end
        count_d    = count_q + CW'(1);
        accepted_d = 1'b1;
        if ((count_q + CW'(1)) == CNT_FULL) begin
          state_d    = S_DONE;
          finished_d = 1'b1;
        end else begin
          state_d    = S_COLLECT;
        end
      end else begin
        invalid_d = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    player_input = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      player_input[k*DIGIT_W +: DIGIT_W] = digits_q[k];
    end
  end

  assign digit_count = count_q;
  assign finished    = finished_q;
  assign accepted    = accepted_q;
  assign invalid     = invalid_q;

endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry: directed scenarios then random presses,
// backspaces and clears checked against a queue-based model of the guess.
module tb_guess_entry;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int D  = 4;
  localparam int SW = 16;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst, en, button, del, clear;
  logic [SW-1:0]     switches;
  logic [N*DW-1:0]   player_input;
  logic [CW-1:0]     digit_count;
  logic              finished, accepted, invalid;

  int compared   = 0;
  int mismatched = 0;
  int q[$];

  always #5 clk = ~clk;

  guess_entry #(.NUM_DIGITS(N), .DIGIT_W(DW), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .switches(switches), .en(en), .button(button),
    .del(del), .clear(clear), .player_input(player_input),
    .digit_count(digit_count), .finished(finished), .accepted(accepted),
    .invalid(invalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ones(input logic [SW-1:0] v);
    int n = 0;
    for (int i = 0; i < SW; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [31:0] model_pack();
    logic [31:0] p = 32'h0;
    foreach (q[k]) p = p + (32'(q[k]) << (k * DW));
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".guess"},    32'(player_input), model_pack());
    check({tag, ".count"},    32'(digit_count),  32'(q.size()));
    check({tag, ".finished"}, 32'(finished),     32'(q.size() == N));
  endtask

  // Hold button for 'hold' edges, then low long enough for the debouncer to settle.
  task automatic press(input string tag, input logic [SW-1:0] sw, input int hold);
    int acc_n = 0, acc_e = 0, inv_n = 0, inv_e = 0, both = 0;
    int exp_acc = 0, exp_inv = 0;
    switches = sw;
    button   = 1'b1;
    for (int e = 1; e <= hold + D + 4; e++) begin
      tick();
      if (e == hold) button = 1'b0;
      if (accepted) begin acc_n++; acc_e = e; end
      if (invalid)  begin inv_n++; inv_e = e; end
      if (accepted && invalid) both++;
    end
    if (hold >= D && en && q.size() < N) begin
      if (ones(sw) == 1) begin
        q.push_back($clog2(int'(sw)));
        exp_acc = 1;
      end else begin
        exp_inv = 1;
      end
    end
    check({tag, ".acc_n"}, 32'(acc_n), 32'(exp_acc));
    check({tag, ".acc_edge"}, 32'(acc_e), exp_acc ? 32'(D + 2) : 32'h0);
    check({tag, ".inv_n"}, 32'(inv_n), 32'(exp_inv));
    check({tag, ".inv_edge"}, 32'(inv_e), exp_inv ? 32'(D + 2) : 32'h0);
    check({tag, ".exclusive"}, 32'(both), 32'h0);
    check_state(tag);
  endtask

  task automatic strobe(input string tag, input logic d, input logic c);
    del   = d;
    clear = c;
    tick();
    del   = 1'b0;
    clear = 1'b0;
    if (c) q.delete();
    else if (d && en && q.size() > 0) void'(q.pop_back());
    check_state(tag);
  endtask

  initial begin
    logic [SW-1:0] sw;
    int acc_e;
    rst = 1'b0; en = 1'b1; button = 1'b0; del = 1'b0; clear = 1'b0; switches = '0;
    tick(); tick();
    check("reset.accepted", 32'(accepted), 32'h0);
    check("reset.invalid",  32'(invalid),  32'h0);
    check_state("reset");
    rst = 1'b1;
    tick();

    // 1: full guess 3,0,15,5
    press("t1.d0", 16'h0008, 10);
    press("t1.d1", 16'h0001, 10);
    press("t1.d2", 16'h8000, 10);
    press("t1.d3", 16'h0020, 10);
    check("t1.guess", 32'(player_input), 32'h5F03);
    strobe("t1.clear", 1'b0, 1'b1);

    // 2: glitch shorter than the debounce window
    press("t2.glitch", 16'h0008, 3);

    // 3: invalid switch patterns
    press("t3.zero",  16'h0000, 10);
    press("t3.multi", 16'h0011, 10);

    // 4: entry with backspace
    press("t4.d7", 16'h0080, 10);
    press("t4.d2", 16'h0004, 10);
    press("t4.d9", 16'h0200, 10);
    strobe("t4.del", 1'b1, 1'b0);
    check("t4.after_del", 32'(player_input), 32'h0027);
    press("t4.d4", 16'h0010, 10);
    press("t4.d1", 16'h0002, 10);
    check("t4.guess", 32'(player_input), 32'h1427);

    // 5: press in DONE ignored, then clear beats del
    press("t5.ignored", 16'h0004, 10);
    strobe("t5.del_clear", 1'b1, 1'b1);

    // 6: reset mid-entry with button held
    press("t6.d3", 16'h0008, 10);
    press("t6.d6", 16'h0040, 10);
    switches = 16'h0020;
    button   = 1'b1;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    q.delete();
    check("t6.async.accepted", 32'(accepted), 32'h0);
    check("t6.async.invalid",  32'(invalid),  32'h0);
    check_state("t6.async");
    tick();
    rst   = 1'b1;
    acc_e = 0;
    for (int e = 1; e <= D + 6; e++) begin
      tick();
      if (accepted) acc_e = e;
    end
    check("t6.replay_edge", 32'(acc_e), 32'(D + 2));
    q.push_back(5);
    button = 1'b0;
    for (int e = 0; e < D + 4; e++) tick();
    check_state("t6.after");
    strobe("t6.clear", 1'b0, 1'b1);

    // random phase
    for (int it = 0; it < 60; it++) begin
      int op;
      en = ($urandom_range(0, 4) != 0);
      op = $urandom_range(0, 9);
      if (op <= 6) begin
        int r = $urandom_range(0, 9);
        if (r < 7)       sw = 16'h0001 << $urandom_range(0, 15);
        else if (r == 7) sw = 16'h0000;
        else             sw = 16'($urandom);
        press("rnd.press", sw, $urandom_range(1, D + 6));
      end else if (op <= 8) begin
        strobe("rnd.del", 1'b1, 1'b0);
      end else begin
        strobe("rnd.clear", 1'b0, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
